// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode constants and sequencer state encoding
package spi_pkg;

  // Mode 0 only: clock idles low, data sampled on the rising edge
  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  // Transfer state, shared with the master sequencer
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchronizer with rise/fall detect
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   q;
  logic                   q_d;
  logic [SYNC_STAGES:0]   primed;

  assign q = chain[SYNC_STAGES-1];

  // Edges are reported only once chain and history hold samples taken after
  // reset, so a line already at its active level when reset drops is not
  // mistaken for a fresh edge.
  assign rise = primed[SYNC_STAGES] & q & ~q_d;
  assign fall = primed[SYNC_STAGES] & ~q & q_d;

  // Shift the raw input through the chain and keep one previous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain  <= {SYNC_STAGES{RESET_VAL}};
      q_d    <= RESET_VAL;
      primed <= '0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], din};
      q_d    <= q;
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - oversampled mode-0 SPI slave with LSB-first word exchange
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;
  logic [0:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-1:0]      tx_hold;
  logic                   word_done;
  logic                   word_start;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI needs no edge detect, only the same delay as sclk so samples line up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign word_done  = (state == ST_ACTIVE) && (bit_cnt == CNT_FULL);
  assign word_start = ((state == ST_IDLE) && cs_fall) || (word_done && !cs_rise);
  assign busy       = (state == ST_ACTIVE);
  assign miso_oe    = busy;
  // The pad driver tristates on miso_oe; the data line itself is just bit 0
  assign miso       = tx_shift[0];

  // Transfer state, bit counter and the sticky framing error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (cs_fall) begin
        state     <= ST_ACTIVE;
        bit_cnt   <= '0;
        frame_err <= 1'b0;
      end
    end else begin
      if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        if (!word_done && (bit_cnt != '0)) begin
          frame_err <= 1'b1;
        end
      end else if (word_done) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Receive shifter and the one-clock delivery of each completed word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (word_done) begin
        rx_data <= rx_shift;
      end else if (busy && sclk_rise) begin
        rx_shift <= {mosi_s, rx_shift[DATA_W-1:1]};
      end
    end
  end

  // Holding register, transmit shifter and underrun reporting. The sclk fall
  // that trails the last rise of a word arrives after the next word has been
  // loaded; bit_cnt is already 0 then, so that fall must not shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold     <= '0;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= word_start && tx_ready;
      if (word_start) begin
        tx_shift <= tx_ready ? '0 : tx_hold;
      end else if (busy && sclk_fall && (bit_cnt != '0)) begin
        tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
      end
      // A load in the same clock as a word start lands after the start has
      // already seen the empty register
      if (tx_load && tx_ready) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end else if (word_start) begin
        tx_ready <= 1'b1;
      end
    end
  end

endmodule
